// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the pipeline hazard sequencer.
// Sequencer state encoding and the hard-wired zero register index.
package cpu_ctrl_pkg;

   typedef enum logic {
      RUN = 1'b0,
      DIV = 1'b1
   } st_t;

   localparam int REG_ZERO = 0;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller bundle: pipeline status in, stage stall/flush out.
// master = the controller, slave = the pipeline datapath.
interface pipeline_hazard_ctrl_if #(
   parameter int REG_W = 5
) ();

   logic [REG_W-1:0] rs_d;
   logic [REG_W-1:0] rt_d;
   logic             branch_d;
   logic [REG_W-1:0] rt_e;
   logic [REG_W-1:0] writereg_e;
   logic             regwrite_e;
   logic             memtoreg_e;
   logic [REG_W-1:0] writereg_m;
   logic             memtoreg_m;
   logic             div_start_e;
   logic             i_stall;
   logic             d_stall;
   logic             exception_m;

   logic stall_f;
   logic stall_d;
   logic stall_e;
   logic stall_m;
   logic stall_w;
   logic flush_d;
   logic flush_e;
   logic flush_m;
   logic flush_w;
   logic div_busy;
   logic exc_flush;

   modport master (
      input  rs_d, rt_d, branch_d,
      input  rt_e, writereg_e,
      input  regwrite_e, memtoreg_e,
      input  writereg_m, memtoreg_m,
      input  div_start_e,
      input  i_stall, d_stall,
      input  exception_m,
      output stall_f, stall_d, stall_e,
      output stall_m, stall_w,
      output flush_d, flush_e,
      output flush_m, flush_w,
      output div_busy, exc_flush
   );

   modport slave (
      output rs_d, rt_d, branch_d,
      output rt_e, writereg_e,
      output regwrite_e, memtoreg_e,
      output writereg_m, memtoreg_m,
      output div_start_e,
      output i_stall, d_stall,
      output exception_m,
      input  stall_f, stall_d, stall_e,
      input  stall_m, stall_w,
      input  flush_d, flush_e,
      input  flush_m, flush_w,
      input  div_busy, exc_flush
   );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational load-use and branch-operand hazard detection.
// Register index zero never forms a dependency.
module hazard_detect
   import cpu_ctrl_pkg::*;
#(
   parameter int REG_W = 5
) (
   input  logic [REG_W-1:0] rs_d,
   input  logic [REG_W-1:0] rt_d,
   input  logic             branch_d,
   input  logic [REG_W-1:0] rt_e,
   input  logic [REG_W-1:0] writereg_e,
   input  logic             regwrite_e,
   input  logic             memtoreg_e,
   input  logic [REG_W-1:0] writereg_m,
   input  logic             memtoreg_m,
   output logic             lwstall,
   output logic             brstall
);

   localparam logic [REG_W-1:0] ZERO = REG_W'(REG_ZERO);

   function automatic logic hits(
      input logic [REG_W-1:0] r,
      input logic [REG_W-1:0] a,
      input logic [REG_W-1:0] b
   );
      return (r != ZERO) && ((r == a) || (r == b));
   endfunction

   logic e_dep;
   logic m_dep;

   assign e_dep = regwrite_e & hits(writereg_e, rs_d, rt_d);
   assign m_dep = memtoreg_m & hits(writereg_m, rs_d, rt_d);

   assign lwstall = memtoreg_e & hits(rt_e, rs_d, rt_d);
   assign brstall = branch_d & (e_dep | m_dep);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline:
// hazards, multi-cycle divide, bus waits and exception flush.
module pipeline_hazard_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int DIV_CYCLES = 32,
   parameter int REG_W      = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   pipeline_hazard_ctrl_if.master hz
);

   localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(DIV_CYCLES - 1);

   st_t           st;
   logic [CW-1:0] div_cnt;
   logic          exc_pend;
   logic          div_done;

   logic lwstall;
   logic brstall;
   logic hz_stall;
   logic mem_stall;
   logic exc_go;
   logic div_enter;
   logic div_last;
   logic div_run;

   logic stall_f;
   logic stall_d;
   logic stall_e;
   logic stall_m;
   logic stall_w;
   logic flush_d;
   logic flush_e;
   logic flush_m;
   logic flush_w;
   logic div_busy;
   logic exc_flush;

   hazard_detect #(
      .REG_W (REG_W)
   ) u_hazard_detect (
      .rs_d       (hz.rs_d),
      .rt_d       (hz.rt_d),
      .branch_d   (hz.branch_d),
      .rt_e       (hz.rt_e),
      .writereg_e (hz.writereg_e),
      .regwrite_e (hz.regwrite_e),
      .memtoreg_e (hz.memtoreg_e),
      .writereg_m (hz.writereg_m),
      .memtoreg_m (hz.memtoreg_m),
      .lwstall    (lwstall),
      .brstall    (brstall)
   );

   assign hz_stall  = lwstall | brstall;
   assign mem_stall = hz.i_stall | hz.d_stall;
   assign exc_go    = (hz.exception_m | exc_pend) & ~mem_stall;

   // div_done blocks a restart by the instruction that follows the divide
   assign div_enter = (st == RUN) & hz.div_start_e & ~div_done;
   assign div_last  = (st == DIV) & (div_cnt == '0);
   assign div_run   = div_enter | ((st == DIV) & ~div_last);

   always_comb begin
      stall_f   = 1'b0;
      stall_d   = 1'b0;
      stall_e   = 1'b0;
      stall_m   = 1'b0;
      stall_w   = 1'b0;
      flush_d   = 1'b0;
      flush_e   = 1'b0;
      flush_m   = 1'b0;
      flush_w   = 1'b0;
      div_busy  = 1'b0;
      exc_flush = 1'b0;
      if (rst) begin
         exc_flush = 1'b0;
      end else if (exc_go) begin
         exc_flush = 1'b1;
         flush_d   = 1'b1;
         flush_e   = 1'b1;
         flush_m   = 1'b1;
         flush_w   = 1'b1;
      end else if (mem_stall) begin
         stall_f  = 1'b1;
         stall_d  = 1'b1;
         stall_e  = 1'b1;
         stall_m  = 1'b1;
         stall_w  = 1'b1;
         div_busy = (st == DIV);
      end else if (div_run) begin
         stall_f  = 1'b1;
         stall_d  = 1'b1;
         stall_e  = 1'b1;
         flush_m  = 1'b1;
         div_busy = 1'b1;
      end else begin
         stall_f = hz_stall;
         stall_d = hz_stall;
         flush_e = hz_stall;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st       <= RUN;
         div_cnt  <= '0;
         exc_pend <= 1'b0;
         div_done <= 1'b0;
      end else if (exc_go) begin
         st       <= RUN;
         div_cnt  <= '0;
         exc_pend <= 1'b0;
         div_done <= 1'b0;
      end else if (mem_stall) begin
         exc_pend <= exc_pend | hz.exception_m;
      end else begin
         exc_pend <= 1'b0;
         div_done <= div_last;
         if (div_enter) begin
            st      <= DIV;
            div_cnt <= CNT_INIT;
         end else if (div_last) begin
            st <= RUN;
         end else if (st == DIV) begin
            div_cnt <= div_cnt - 1'b1;
         end
      end
   end

   assign hz.stall_f   = stall_f;
   assign hz.stall_d   = stall_d;
   assign hz.stall_e   = stall_e;
   assign hz.stall_m   = stall_m;
   assign hz.stall_w   = stall_w;
   assign hz.flush_d   = flush_d;
   assign hz.flush_e   = flush_e;
   assign hz.flush_m   = flush_m;
   assign hz.flush_w   = flush_w;
   assign hz.div_busy  = div_busy;
   assign hz.exc_flush = exc_flush;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_pipeline_hazard_ctrl;

   localparam int DIVC = 4;

   // {stall_f,d,e,m,w, flush_d,e,m,w, div_busy, exc_flush}
   localparam logic [10:0] V_IDLE = 11'b00000_0000_00;
   localparam logic [10:0] V_BUB  = 11'b11000_0100_00;
   localparam logic [10:0] V_DIV  = 11'b11100_0010_10;
   localparam logic [10:0] V_MSD  = 11'b11111_0000_10;
   localparam logic [10:0] V_MS   = 11'b11111_0000_00;
   localparam logic [10:0] V_EXC  = 11'b00000_1111_01;

   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl_if #(.REG_W(5)) hz ();

   pipeline_hazard_ctrl #(
      .DIV_CYCLES (DIVC),
      .REG_W      (5)
   ) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz)
   );

   function automatic logic [10:0] outs();
      return {hz.stall_f, hz.stall_d, hz.stall_e,
              hz.stall_m, hz.stall_w,
              hz.flush_d, hz.flush_e, hz.flush_m,
              hz.flush_w, hz.div_busy, hz.exc_flush};
   endfunction

   task automatic chk(input string nm,
                      input logic [10:0] got,
                      input logic [10:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t",
                  nm, got, exp, $time);
      end
   endtask

   // Model: count unstalled cycles a divide has spent in E.
   bit m_div, m_guard, m_pend, armed;
   int m_occ;

   initial begin
      m_div = 0; m_guard = 0; m_pend = 0;
      m_occ = 0; armed = 0;
      forever begin
         bit ms, ex, lw, br, start, dstall;
         logic [10:0] e;
         @(negedge clk);
         ms = hz.i_stall || hz.d_stall;
         ex = (hz.exception_m || m_pend) && !ms;
         lw = hz.memtoreg_e && hz.rt_e != 0 &&
              (hz.rt_e == hz.rs_d || hz.rt_e == hz.rt_d);
         br = hz.branch_d &&
              ((hz.regwrite_e && hz.writereg_e != 0 &&
                (hz.writereg_e == hz.rs_d ||
                 hz.writereg_e == hz.rt_d)) ||
               (hz.memtoreg_m && hz.writereg_m != 0 &&
                (hz.writereg_m == hz.rs_d ||
                 hz.writereg_m == hz.rt_d)));
         start  = !m_div && hz.div_start_e && !m_guard;
         dstall = start || (m_div && m_occ < DIVC);
         e = V_IDLE;
         if (rst) e = V_IDLE;
         else if (ex) e = V_EXC;
         else if (ms) e = {5'b11111, 4'b0000, m_div, 1'b0};
         else if (dstall) e = V_DIV;
         else if (lw || br) e = V_BUB;
         if (rst) armed = 1;
         if (armed) chk("model", outs(), e);
         if (rst) begin
            m_div = 0; m_guard = 0; m_pend = 0; m_occ = 0;
         end else if (ex) begin
            m_div = 0; m_guard = 0; m_pend = 0; m_occ = 0;
         end else if (ms) begin
            m_pend = m_pend || hz.exception_m;
         end else begin
            m_pend = 0;
            m_guard = m_div && m_occ == DIVC;
            if (start) begin
               m_div = 1; m_occ = 1;
            end else if (m_div && m_occ == DIVC) begin
               m_div = 0; m_occ = 0;
            end else if (m_div) begin
               m_occ++;
            end
         end
      end
   end

   task automatic clr();
      hz.rs_d = 0; hz.rt_d = 0; hz.branch_d = 0;
      hz.rt_e = 0; hz.writereg_e = 0;
      hz.regwrite_e = 0; hz.memtoreg_e = 0;
      hz.writereg_m = 0; hz.memtoreg_m = 0;
      hz.div_start_e = 0; hz.i_stall = 0;
      hz.d_stall = 0; hz.exception_m = 0;
   endtask

   task automatic cyc(input string nm, input logic [10:0] e);
      @(negedge clk);
      chk(nm, outs(), e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      clr();
      rst = 1;
      hz.memtoreg_e = 1; hz.rt_e = 2; hz.rs_d = 2;
      hz.div_start_e = 1; hz.d_stall = 1; hz.exception_m = 1;
      cyc("reset0", V_IDLE);
      cyc("reset1", V_IDLE);
      rst = 0; clr();
      cyc("post_reset", V_IDLE);

      hz.memtoreg_e = 1; hz.rt_e = 2; hz.rs_d = 2;
      cyc("load_use", V_BUB);
      hz.rt_e = 0; hz.rs_d = 0;
      cyc("load_use_r0", V_IDLE);
      clr();

      hz.branch_d = 1; hz.rs_d = 5;
      hz.regwrite_e = 1; hz.writereg_e = 5;
      cyc("branch_alu", V_BUB);
      hz.regwrite_e = 0; hz.memtoreg_m = 0;
      cyc("branch_release", V_IDLE);
      clr();

      hz.div_start_e = 1;
      for (int i = 0; i < DIVC; i++) cyc("div_busy", V_DIV);
      cyc("div_done", V_IDLE);
      cyc("div_no_restart", V_IDLE);
      clr();
      cyc("div_idle", V_IDLE);

      hz.div_start_e = 1;
      cyc("divs_enter", V_DIV);
      hz.div_start_e = 0;
      cyc("divs_run", V_DIV);
      hz.d_stall = 1;
      for (int i = 0; i < 3; i++) cyc("divs_dstall", V_MSD);
      hz.d_stall = 0;
      cyc("divs_run2", V_DIV);
      cyc("divs_run3", V_DIV);
      cyc("divs_done", V_IDLE);
      cyc("divs_idle", V_IDLE);

      hz.d_stall = 1; hz.exception_m = 1;
      cyc("exc_held0", V_MS);
      hz.exception_m = 0;
      cyc("exc_held1", V_MS);
      hz.d_stall = 0;
      cyc("exc_fire", V_EXC);
      cyc("exc_after", V_IDLE);

      hz.div_start_e = 1;
      cyc("rstdiv_enter", V_DIV);
      rst = 1;
      cyc("rstdiv_rst", V_IDLE);
      rst = 0; hz.div_start_e = 0;
      for (int i = 0; i < 6; i++) cyc("rstdiv_quiet", V_IDLE);
      hz.div_start_e = 1;
      cyc("rstdiv_restart", V_DIV);
      hz.div_start_e = 0;
      for (int i = 0; i < DIVC - 1; i++) cyc("rstdiv_run", V_DIV);
      cyc("rstdiv_done", V_IDLE);

      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 199) == 0);
         hz.rs_d = 5'($urandom_range(0, 3));
         hz.rt_d = 5'($urandom_range(0, 3));
         hz.rt_e = 5'($urandom_range(0, 3));
         hz.writereg_e = 5'($urandom_range(0, 3));
         hz.writereg_m = 5'($urandom_range(0, 3));
         hz.branch_d = ($urandom_range(0, 3) == 0);
         hz.regwrite_e = ($urandom_range(0, 1) == 0);
         hz.memtoreg_e = ($urandom_range(0, 3) == 0);
         hz.memtoreg_m = ($urandom_range(0, 3) == 0);
         hz.div_start_e = ($urandom_range(0, 5) == 0);
         hz.i_stall = ($urandom_range(0, 9) == 0);
         hz.d_stall = ($urandom_range(0, 7) == 0);
         hz.exception_m = ($urandom_range(0, 39) == 0);
         @(posedge clk);
         #1;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline. It drives the en (via stall_x, active-high, en = ~stall_x) and clear (flush_x) inputs of every F/D, D/E, E/M and M/W enable-clear pipeline register, plus the PC register enable. It resolves load-use and branch-operand hazards, sequences multi-cycle divides and memory-wait stalls, and holds exception flushes until outstanding bus transactions retire.

Parameters:
DIV_CYCLES, 32, cycles the divider occupies E (>=2)
REG_W, 5, register-specifier width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
rs_d, rt_d  in  REG_W  source specifiers in D
branch_d  in  1  D holds a branch/jr needing operands in D
rt_e  in  REG_W  rt of instruction in E
writereg_e  in  REG_W  destination in E
regwrite_e, memtoreg_e  in  1  E writes reg / E is a load
writereg_m  in  REG_W  destination in M
memtoreg_m  in  1  M is a load
div_start_e  in  1  E holds div/divu (level while in E)
i_stall, d_stall  in  1  instruction/data bus wait
exception_m  in  1  exception detected in M (pulse)
stall_f, stall_d, stall_e, stall_m, stall_w  out  1  hold stage register
flush_d, flush_e, flush_m, flush_w  out  1  clear stage register
div_busy  out  1  divider sequencing active
exc_flush  out  1  one-cycle pulse: redirect PC to handler

Behaviour:
- State (registered): st in {RUN, DIV}, div_cnt[$clog2(DIV_CYCLES)-1:0], exc_pend. Outputs combinational from state + inputs.
- rst high: st=RUN, div_cnt=0, exc_pend=0; all outputs 0 in that cycle. Reset mid-divide aborts it, with no done pulse.
- mem_stall = i_stall | d_stall.
- Priority, highest first: exception flush > mem_stall > DIV > branch hazard / load-use.
- Exception: exception_m sets exc_pend (or acts directly if mem_stall=0). When (exception_m | exc_pend) & ~mem_stall: exc_flush=1, flush_d=flush_e=flush_m=flush_w=1, all stalls 0, exc_pend<=0, st<=RUN (divide aborted). While mem_stall=1 the exception is held: exc_pend=1, mem_stall rules apply.
- mem_stall (no exception firing): all five stalls=1, all flushes 0, and div_cnt frozen.
- Load-use: lwstall = memtoreg_e & rt_e!=0 & (rt_e==rs_d | rt_e==rt_d).
- Branch hazard: brstall = branch_d & ((regwrite_e & writereg_e!=0 & (writereg_e==rs_d|writereg_e==rt_d)) | (memtoreg_m & writereg_m!=0 & (writereg_m==rs_d|writereg_m==rt_d))).
- lwstall|brstall in RUN: stall_f=stall_d=1 and flush_e=1 (bubble); E/M/W advance.
- RUN & div_start_e & no higher event: st<=DIV, div_cnt<=DIV_CYCLES-1. The entry cycle already stalls (see DIV).
- DIV: div_busy=1, stall_f=stall_d=stall_e=1, flush_m=1 (bubbles into M); div_cnt decrements per unstalled cycle. At div_cnt==0: st<=RUN, and this cycle stall_e=0, so E advances with the result; stall_f/stall_d follow lwstall/brstall. Total E occupancy is DIV_CYCLES+1 cycles with no mem_stall.
- A div_start_e still high in the cycle after leaving DIV does not restart the divide, because E now holds a new instruction. Use a one-cycle div_done guard flag.
- Register index 0 never creates a hazard.

Decomposition:
- Shared package cpu_ctrl_pkg: st encoding typedef (RUN, DIV) and REG_ZERO constant.
- One natural sub-module: hazard_detect (combinational lwstall/brstall). The FSM, counter and exception logic stay in the top.

Test Plan:
- Load-use: lw $2 in E (memtoreg_e=1, rt_e=2), rs_d=2 -> for one cycle stall_f=stall_d=1, flush_e=1, others 0. Same case with rt_e=0 -> no stall.
- Branch after ALU op: branch_d=1, rs_d=5, regwrite_e=1, writereg_e=5 -> stall_f/stall_d/flush_e=1. Next cycle, with memtoreg_m=0 -> released.
- Divide, DIV_CYCLES=4: div_start_e pulse -> div_busy=1, stall_e=1 and flush_m=1 for 4 cycles. On the 5th cycle stall_e=0, div_busy=0, st=RUN, with no restart.
- d_stall=1 for 3 cycles mid-divide -> all stalls=1 and div_cnt frozen. The divide completes 3 cycles later than without the stall.
- exception_m pulse while d_stall=1 for 2 cycles -> exc_pend=1, and no flush while stalled. In the first cycle d_stall=0: exc_flush=1, flush_d/e/m/w=1, stalls 0.
- rst asserted in the 2nd DIV cycle -> next cycle st=RUN, div_busy=0, all outputs 0, and no spurious completion.
